dac_mode_sequencer: RTL and testbench
=====================================

# dac_mode_sequencer

Sequences DAC mode changes: mute, DAC reset, clock/format switch, settle and unmute. It sits between the MCU control inputs and the DAC control outputs and clock-select muxing in the snos top level. It qualifies a requested mode word, such as {44/48, rate, DSD/PCM, MCLK select}. It then walks the DAC through a click-free transition and publishes the applied mode to the clock-select and NOS datapath logic. MCU mute and reset requests pass through as overrides.

## Interface
- `MODE_W`, default 7: mode word width.
- `CNT_W`, default 16: state-timer width. Every `*_CYC` value must satisfy `1 ≤ *_CYC < 2^CNT_W`.
- `DEBOUNCE_CYC`, default 1024: cycles `mode_in` must stay stable before a change is accepted.
- `MUTE_CYC`, default 4096: mute ramp hold before reset.
- `RESET_CYC`, default 256: DAC reset pulse length.
- `SETTLE_CYC`, default 16384: PLL/MCLK settle time after apply.
- `clk`  in  1  system clock. The block has one clock.
- `resetn`  in  1  synchronous, active-low reset.
- `mode_in`  in  MODE_W  requested mode word; quasi-static and already synchronised to `clk`.
- `mcu_mute`  in  1  MCU mute request, active-high.
- `mcu_dac_reset`  in  1  MCU DAC reset request, active-high.
- `mclk_ok`  in  1  MCLK activity flag from the indicator logic.
- `mode_out`  out  MODE_W  applied mode word; drives clock-select and NOS configuration.
- `mode_strobe`  out  1  one-cycle pulse when `mode_out` updates.
- `dac_mute`  out  1  DAC mute, active-high.
- `dac_rst_n`  out  1  DAC reset, active-low.
- `busy`  out  1  high in every state except RUN.

## Operation
- FSM states: RUN, QUAL, MUTE, RST, APPLY, SETTLE. One shared timer `cnt` is cleared on every state entry.
- `prev_mode` is `mode_in` registered once; "change" means `mode_in != prev_mode`.
- **RUN:** if `mode_in != mode_out`, go to QUAL.
- **QUAL:**
  - If `mode_in == mode_out`, return to RUN. This is a glitch: no mute occurs.
  - Otherwise a change clears `cnt`.
  - When `cnt == DEBOUNCE_CYC-1`, go to MUTE.
- **MUTE:** after MUTE_CYC cycles, go to RST. `mode_in` activity is ignored here.
- **RST:**
  - A change clears `cnt`.
  - After RESET_CYC cycles without a change, go to APPLY.
- **APPLY:** lasts exactly 1 cycle. Set `mode_out <= mode_in`, pulse `mode_strobe`, then go to SETTLE.
- **SETTLE:**
  - If `mode_in != mode_out`, go to RST with `cnt` cleared. The DAC is already muted, so there is no re-qualify.
  - After SETTLE_CYC cycles, go to RUN.
- Sequencer mute = 1 in MUTE, RST, APPLY and SETTLE.
- Sequencer reset = 1 in RST and APPLY.
- All outputs are registered:
  - `dac_mute <= seq_mute | mcu_mute`
  - `dac_rst_n <= ~(seq_rst | mcu_dac_reset)`
  - `busy <= (next_state != RUN)`
- Overrides never alter the FSM.
- Reset (`resetn` = 0 at a rising edge) forces the following, mid-sequence included:
  - state = RST, `cnt` = 0
  - `mode_out` = 0, `mode_strobe` = 0
  - `dac_mute` = 1, `dac_rst_n` = 0, `busy` = 1
  - `prev_mode` = 0
- After reset the block always performs RST→APPLY→SETTLE→RUN, so the first mode is applied without qualification.

## Timing
- Latencies assume a stable step in `mode_in` arriving in RUN.
- QUAL is entered at edge T+1.
- `dac_mute` rises 1 cycle after MUTE entry, at edge T+1+DEBOUNCE_CYC+1.
- `dac_rst_n` falls MUTE_CYC cycles after mute rises.
- `mode_strobe` is high in the cycle following RST completion.
- `dac_rst_n` rises 1 cycle after SETTLE entry.
- `dac_mute` falls SETTLE_CYC+1 cycles after the strobe, provided `mcu_mute` = 0.
- Total from the first mismatch edge to unmute: DEBOUNCE_CYC + MUTE_CYC + RESET_CYC + 1 + SETTLE_CYC + 1 cycles.
- Override latency: 1 cycle.
- Simultaneous events:
  - A SETTLE completion and a mismatch in the same cycle go to RST; the mismatch wins.
  - A QUAL timeout and a return to `mode_out` in the same cycle go to RUN.

## Configuration
- Macro: `DAC_MODE_SEQ_MCLK_WAIT_EN`.
- Defined:
  - The SETTLE timer advances only while `mclk_ok` = 1.
  - `mclk_ok` = 0 clears `cnt`, so SETTLE requires SETTLE_CYC consecutive cycles with MCLK present.
  - The DAC stays muted indefinitely if MCLK never appears.
- Undefined: `mclk_ok` is ignored (the port stays present but unused), and SETTLE is purely timed.

## Test plan
All scenarios use DEBOUNCE_CYC=4, MUTE_CYC=8, RESET_CYC=4, SETTLE_CYC=16 and `mcu_*` = 0 unless stated.
- **Reset:** hold `resetn` = 0 for 3 cycles with `mode_in` = 7'h15. Expect `dac_mute` = 1, `dac_rst_n` = 0, `mode_out` = 0 and `busy` = 1 during reset. After release: `mode_strobe` pulses once with `mode_out` = 7'h15, then `dac_rst_n` = 1, then `dac_mute` = 0 and `busy` = 0.
- **Glitch:** in RUN, drive `mode_in` to 7'h2A for 3 cycles, then back to 7'h15. Expect no `dac_mute` or `mode_strobe`, and `mode_out` stays 7'h15.
- **Change:** step `mode_in` to 7'h2A and hold. Expect mute rise at +6, reset low at +14, a single strobe with `mode_out` = 7'h2A, and unmute at +35.
- **Change during SETTLE:** drive `mode_in` to 7'h33 at SETTLE cycle 5. Expect a return to RST (`dac_rst_n` = 0), a second strobe with 7'h33, and `dac_mute` held at 1 throughout.
- **Overrides in RUN:**
  - `mcu_mute` = 1 gives `dac_mute` = 1 on the next cycle with state unchanged.
  - `mcu_dac_reset` = 1 gives `dac_rst_n` = 0 on the next cycle.
  - Neither override produces a `mode_strobe`.
- **Macro defined:** pull `mclk_ok` low for 10 cycles mid-SETTLE. Expect unmute delayed until 16 consecutive `mclk_ok`-high cycles. With the macro undefined, unmute timing is identical to the Change scenario.

Source files
------------

// File: rtl/dac_mode_sequencer.sv
// Sequences click-free DAC mode changes: qualify, mute, DAC reset, apply, settle, unmute.
// Optional DAC_MODE_SEQ_MCLK_WAIT_EN: SETTLE timer only advances while mclk_ok is high.
module dac_mode_sequencer #(
    parameter int MODE_W       = 7,
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int MUTE_CYC     = 4096,
    parameter int RESET_CYC    = 256,
    parameter int SETTLE_CYC   = 16384
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              mcu_mute,
    input  logic              mcu_dac_reset,
    input  logic              mclk_ok,
    output logic [MODE_W-1:0] mode_out,
    output logic              mode_strobe,
    output logic              dac_mute,
    output logic              dac_rst_n,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_RUN,
        S_QUAL,
        S_MUTE,
        S_RST,
        S_APPLY,
        S_SETTLE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_clr;
    logic [MODE_W-1:0] prev_mode;
    logic              change;
    logic              mismatch;
    logic              seq_mute;
    logic              seq_rst;

    assign change   = (mode_in != prev_mode);
    assign mismatch = (mode_in != mode_out);

`ifdef DAC_MODE_SEQ_MCLK_WAIT_EN
    logic settle_hold;
    assign settle_hold = ~mclk_ok;
`else
    logic settle_hold;
    logic mclk_ok_unused;
    assign settle_hold    = 1'b0;
    assign mclk_ok_unused = mclk_ok;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_RST;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        case (state)
            S_RUN: begin
                if (mismatch) next_state = S_QUAL;
            end
            S_QUAL: begin
                // Returning to the applied mode beats a debounce timeout.
                if (!mismatch)             next_state = S_RUN;
                else if (change)           cnt_clr    = 1'b1;
                else if (cnt == DEB_LAST)  next_state = S_MUTE;
            end
            S_MUTE: begin
                if (cnt == MUTE_LAST) next_state = S_RST;
            end
            S_RST: begin
                if (change)               cnt_clr    = 1'b1;
                else if (cnt == RST_LAST) next_state = S_APPLY;
            end
            S_APPLY: begin
                next_state = S_SETTLE;
            end
            S_SETTLE: begin
                // Already muted: a new request goes straight back to reset.
                if (mismatch)                next_state = S_RST;
                else if (settle_hold)        cnt_clr    = 1'b1;
                else if (cnt == SETTLE_LAST) next_state = S_RUN;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
        if (next_state != state) cnt_clr = 1'b1;
    end

    always_comb begin
        seq_mute = (state == S_MUTE) || (state == S_RST) ||
                   (state == S_APPLY) || (state == S_SETTLE);
        seq_rst  = (state == S_RST) || (state == S_APPLY);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt         <= '0;
            prev_mode   <= '0;
            mode_out    <= '0;
            mode_strobe <= 1'b0;
            dac_mute    <= 1'b1;
            dac_rst_n   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            cnt         <= cnt_clr ? '0 : cnt + CNT_W'(1);
            prev_mode   <= mode_in;
            mode_strobe <= (state == S_APPLY);
            if (state == S_APPLY) mode_out <= mode_in;
            dac_mute    <= seq_mute | mcu_mute;
            dac_rst_n   <= ~(seq_rst | mcu_dac_reset);
            busy        <= (next_state != S_RUN);
        end
    end

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// Directed + randomized bench for dac_mode_sequencer against a countdown-based reference model.
module tb_dac_mode_sequencer;

    localparam int D = 4;
    localparam int M = 8;
    localparam int R = 4;
    localparam int S = 16;
    localparam int TS = D + M + R + 2;  // strobe edge after a step seen in RUN

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] mode_in;
    logic       mcu_mute;
    logic       mcu_dac_reset;
    logic       mclk_ok;
    logic [6:0] mode_out;
    logic       mode_strobe;
    logic       dac_mute;
    logic       dac_rst_n;
    logic       busy;

    always #5 clk = ~clk;

    dac_mode_sequencer #(
        .MODE_W(7), .CNT_W(16),
        .DEBOUNCE_CYC(D), .MUTE_CYC(M), .RESET_CYC(R), .SETTLE_CYC(S)
    ) dut (
        .clk(clk), .resetn(resetn), .mode_in(mode_in),
        .mcu_mute(mcu_mute), .mcu_dac_reset(mcu_dac_reset), .mclk_ok(mclk_ok),
        .mode_out(mode_out), .mode_strobe(mode_strobe),
        .dac_mute(dac_mute), .dac_rst_n(dac_rst_n), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase plus cycles-remaining countdown.
    localparam int P_RUN = 0, P_QUAL = 1, P_MUTE = 2, P_RST = 3, P_APPLY = 4, P_SETTLE = 5;
    int         m_ph;
    int         m_left;
    logic [6:0] m_prev, m_out;
    logic       m_strobe, m_mute, m_rstn, m_busy;

    task automatic model_step();
        int nph;
        int nleft;
        bit chg;
        if (!resetn) begin
            m_ph = P_RST; m_left = R; m_prev = 0; m_out = 0;
            m_strobe = 0; m_mute = 1; m_rstn = 0; m_busy = 1;
            return;
        end
        chg   = (mode_in != m_prev);
        nph   = m_ph;
        nleft = m_left - 1;
        case (m_ph)
            P_RUN:    if (mode_in != m_out) begin nph = P_QUAL; nleft = D; end
            P_QUAL: begin
                if (mode_in == m_out) nph = P_RUN;
                else if (chg)         nleft = D;
                else if (m_left == 1) begin nph = P_MUTE; nleft = M; end
            end
            P_MUTE:   if (m_left == 1) begin nph = P_RST; nleft = R; end
            P_RST: begin
                if (chg)              nleft = R;
                else if (m_left == 1) begin nph = P_APPLY; nleft = 1; end
            end
            P_APPLY:  begin nph = P_SETTLE; nleft = S; end
            default: begin
                if (mode_in != m_out) begin nph = P_RST; nleft = R; end
`ifdef DAC_MODE_SEQ_MCLK_WAIT_EN
                else if (!mclk_ok)    nleft = S;
`endif
                else if (m_left == 1) nph = P_RUN;
            end
        endcase
        m_mute   = (m_ph >= P_MUTE) || mcu_mute;
        m_rstn   = !((m_ph == P_RST) || (m_ph == P_APPLY) || mcu_dac_reset);
        m_strobe = (m_ph == P_APPLY);
        if (m_ph == P_APPLY) m_out = mode_in;
        m_busy   = (nph != P_RUN);
        m_prev   = mode_in;
        m_ph     = nph;
        m_left   = nleft;
    endtask

    // Event log relative to the last clr_events().
    int         edge_n;
    int         n_strobe, t_strobe, t_strobe_last, n_mute_fall;
    int         t_mute_rise, t_mute_fall, t_rst_fall, t_rst_fall_last, t_rst_rise;
    logic [6:0] strobe_mode;
    logic       p_mute = 1'b1;
    logic       p_rstn = 1'b0;

    task automatic clr_events();
        edge_n = 0; n_strobe = 0; n_mute_fall = 0;
        t_strobe = -1; t_strobe_last = -1; t_mute_rise = -1; t_mute_fall = -1;
        t_rst_fall = -1; t_rst_fall_last = -1; t_rst_rise = -1;
        strobe_mode = 'x;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cyc_mode_out", mode_out, m_out);
        chk("cyc_strobe", mode_strobe, m_strobe);
        chk("cyc_dac_mute", dac_mute, m_mute);
        chk("cyc_dac_rst_n", dac_rst_n, m_rstn);
        chk("cyc_busy", busy, m_busy);
        edge_n++;
        if (mode_strobe === 1'b1) begin
            n_strobe++;
            if (t_strobe < 0) t_strobe = edge_n;
            t_strobe_last = edge_n;
            strobe_mode = mode_out;
        end
        if (dac_mute === 1'b1 && p_mute === 1'b0 && t_mute_rise < 0) t_mute_rise = edge_n;
        if (dac_mute === 1'b0 && p_mute === 1'b1) begin n_mute_fall++; t_mute_fall = edge_n; end
        if (dac_rst_n === 1'b0 && p_rstn === 1'b1) begin
            if (t_rst_fall < 0) t_rst_fall = edge_n;
            t_rst_fall_last = edge_n;
        end
        if (dac_rst_n === 1'b1 && p_rstn === 1'b0 && t_rst_rise < 0) t_rst_rise = edge_n;
        p_mute = dac_mute;
        p_rstn = dac_rst_n;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [6:0] cur, nxt;
        int         len, exp_unmute;

        resetn = 0; mode_in = 7'h15; mcu_mute = 0; mcu_dac_reset = 0; mclk_ok = 1;
        clr_events();
        run(3);
        chk("rst_dac_mute", dac_mute, 1);
        chk("rst_dac_rst_n", dac_rst_n, 0);
        chk("rst_mode_out", mode_out, 0);
        chk("rst_busy", busy, 1);
        chk("rst_strobe", mode_strobe, 0);

        // Boot: first edge sees prev_mode=0 vs 15, restarting the RST timer once.
        resetn = 1; clr_events(); run(30);
        chk("boot_n_strobe", n_strobe, 1);
        chk("boot_t_strobe", t_strobe, R + 2);
        chk("boot_strobe_mode", strobe_mode, 7'h15);
        chk("boot_t_rst_rise", t_rst_rise, R + 3);
        chk("boot_t_mute_fall", t_mute_fall, R + S + 3);
        chk("boot_busy", busy, 0);

        // Glitches no longer than the debounce window never mute.
        cur = 7'h15;
        for (int g = 0; g < 4; g++) begin
            if (g == 0) begin nxt = 7'h2A; len = 3; end
            else begin
                nxt = 7'($urandom_range(0, 127));
                if (nxt == cur) nxt = ~cur;
                len = (g == 1) ? D : $urandom_range(1, D);
            end
            clr_events();
            mode_in = nxt; run(len);
            mode_in = cur; run(12);
            chk("glitch_n_strobe", n_strobe, 0);
            chk("glitch_mute_rise", t_mute_rise, -1);
            chk("glitch_mode_out", mode_out, cur);
            chk("glitch_busy", busy, 0);
        end

        // Full change sequences: 2A, then a random word.
        for (int c = 0; c < 2; c++) begin
            nxt = (c == 0) ? 7'h2A : 7'($urandom_range(0, 127));
            if (nxt == cur) nxt = cur ^ 7'h01;
            clr_events();
            mode_in = nxt; run(40);
            chk("chg_t_mute_rise", t_mute_rise, D + 2);
            chk("chg_t_rst_fall", t_rst_fall, D + 2 + M);
            chk("chg_n_strobe", n_strobe, 1);
            chk("chg_t_strobe", t_strobe, TS);
            chk("chg_strobe_mode", strobe_mode, nxt);
            chk("chg_t_rst_rise", t_rst_rise, TS + 1);
            chk("chg_t_mute_fall", t_mute_fall, D + M + R + S + 3);
            chk("chg_busy", busy, 0);
            cur = nxt;
        end

        // Overrides in RUN.
        clr_events();
        mcu_mute = 1; run(1);
        chk("ovr_mute_on", dac_mute, 1);
        chk("ovr_mute_busy", busy, 0);
        mcu_mute = 0; run(1);
        chk("ovr_mute_off", dac_mute, 0);
        mcu_dac_reset = 1; run(1);
        chk("ovr_rst_on", dac_rst_n, 0);
        mcu_dac_reset = 0; run(3);
        chk("ovr_rst_off", dac_rst_n, 1);
        chk("ovr_n_strobe", n_strobe, 0);
        chk("ovr_mode_out", mode_out, cur);

        // New request at SETTLE cycle 5 goes back to RST while staying muted.
        nxt = (cur == 7'h4C) ? 7'h4D : 7'h4C;
        clr_events();
        mode_in = nxt; run(TS + 5);
        mode_in = 7'h33; run(30);
        chk("rsettle_n_strobe", n_strobe, 2);
        chk("rsettle_t_rst_fall2", t_rst_fall_last, TS + 7);
        chk("rsettle_t_strobe2", t_strobe_last, TS + 7 + R);
        chk("rsettle_strobe_mode", strobe_mode, 7'h33);
        chk("rsettle_n_mute_fall", n_mute_fall, 1);
        chk("rsettle_t_mute_fall", t_mute_fall, TS + 7 + R + S + 1);
        cur = 7'h33;

        // MCLK dropout for 10 cycles mid-SETTLE.
        clr_events();
        mode_in = 7'h0F; run(TS + 5);
        mclk_ok = 0; run(10);
        mclk_ok = 1; run(40);
`ifdef DAC_MODE_SEQ_MCLK_WAIT_EN
        exp_unmute = TS + 5 + 10 + S + 1;
`else
        exp_unmute = TS + S + 1;
`endif
        chk("mclk_t_mute_fall", t_mute_fall, exp_unmute);
        chk("mclk_mode_out", mode_out, 7'h0F);

        // Random traffic, including one mid-sequence reset.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) mode_in = 7'($urandom_range(0, 127));
            else if (r < 6) mode_in = mode_in ^ 7'($urandom_range(1, 127));
            mcu_mute      = ($urandom_range(0, 7) == 0);
            mcu_dac_reset = ($urandom_range(0, 7) == 0);
            mclk_ok       = ($urandom_range(0, 3) != 0);
            if (i == 75) begin resetn = 0; run(2); resetn = 1; end
            run($urandom_range(1, 30));
        end
        mcu_mute = 0; mcu_dac_reset = 0; mclk_ok = 1;
        run(80);
        chk("final_busy", busy, 0);
        chk("final_mute", dac_mute, 0);
        chk("final_mode_out", mode_out, mode_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
